step_rate_meter: RTL and testbench



---
 rtl/step_rate_meter.sv | 95 +++++++++
 tb/tb_step_rate_meter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/step_rate_meter.sv
// Per-window step counter: synchronises slowclk/step, counts steps between slowclk edges, publishes rate via valid/ack.
// Latency: input edge to effect in 3 fastclk cycles; no backpressure, a new window overwrites an unread rate and sets overrun.
module step_rate_meter #(
    parameter int CNT_W      = 8,
    parameter int WIN_W      = 16,
    parameter int HI_THRESH  = 32,
    parameter int HI_WINDOWS = 60
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             slowclk,
    input  logic             step,
    input  logic             rd_ack,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             overrun,
    output logic [WIN_W-1:0] window_cnt,
    output logic             high_activity
);

    localparam logic [7:0]       HI_LIMIT = 8'(HI_WINDOWS);
    localparam logic [CNT_W-1:0] ACC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    logic [1:0]       slow_sync;
    logic             slow_hist;
    logic [1:0]       step_sync;
    logic             step_hist;
    logic [1:0]       arm;
    logic             armed;
    logic             boundary;
    logic             step_pulse;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_next;
    logic [7:0]       streak;

    // History flops keep tracking while disarmed so levels present at reset release are absorbed.
    assign armed      = &arm;
    assign boundary   = armed & (slow_sync[1] ^ slow_hist);
    assign step_pulse = armed & step_sync[1] & ~step_hist;

    always_comb begin
        acc_next = acc;
        if (step_pulse && !(&acc)) begin
            acc_next = acc + ACC_ONE;
        end
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            slow_sync     <= 2'b00;
            slow_hist     <= 1'b0;
            step_sync     <= 2'b00;
            step_hist     <= 1'b0;
            arm           <= 2'd0;
            acc           <= '0;
            rate          <= '0;
            rate_valid    <= 1'b0;
            overrun       <= 1'b0;
            window_cnt    <= '0;
            streak        <= 8'd0;
            high_activity <= 1'b0;
        end else begin
            slow_sync     <= {slow_sync[0], slowclk};
            slow_hist     <= slow_sync[1];
            step_sync     <= {step_sync[0], step};
            step_hist     <= step_sync[1];
            high_activity <= (streak == HI_LIMIT);
            if (!armed) begin
                arm <= arm + 2'd1;
            end
            if (boundary) begin
                // A step coincident with the boundary belongs to the closing window.
                rate       <= acc_next;
                acc        <= '0;
                rate_valid <= 1'b1;
                window_cnt <= window_cnt + WIN_ONE;
                if (rate_valid) begin
                    overrun <= 1'b1;
                end
                if (int'(acc_next) >= HI_THRESH) begin
                    streak <= (streak == HI_LIMIT) ? streak : streak + 8'd1;
                end else begin
                    streak <= 8'd0;
                end
            end else begin
                acc <= acc_next;
                if (rd_ack) begin
                    rate_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_rate_meter.sv
// Bench for step_rate_meter: directed scenarios plus random traffic, all checked every cycle against a sample-history model.
module tb_step_rate_meter;

    localparam int CNT_W      = 8;
    localparam int WIN_W      = 4;
    localparam int HI_THRESH  = 32;
    localparam int HI_WINDOWS = 3;
    localparam int MAXV       = (1 << CNT_W) - 1;

    logic             fastclk = 1'b0;
    logic             reset   = 1'b1;
    logic             slowclk = 1'b0;
    logic             step    = 1'b0;
    logic             rd_ack  = 1'b0;
    logic [CNT_W-1:0] rate;
    logic             rate_valid;
    logic             overrun;
    logic [WIN_W-1:0] window_cnt;
    logic             high_activity;

    int n_cmp = 0;
    int n_err = 0;

    always #5 fastclk = ~fastclk;

    step_rate_meter #(
        .CNT_W(CNT_W), .WIN_W(WIN_W), .HI_THRESH(HI_THRESH), .HI_WINDOWS(HI_WINDOWS)
    ) dut (
        .fastclk(fastclk), .reset(reset), .slowclk(slowclk), .step(step), .rd_ack(rd_ack),
        .rate(rate), .rate_valid(rate_valid), .overrun(overrun),
        .window_cnt(window_cnt), .high_activity(high_activity)
    );

    // Model: inputs as sampled at each edge, newest first; a change two/three samples back is a detected edge.
    bit          m_init = 1'b0;
    bit          sq_slow[$];
    bit          sq_step[$];
    int          m_live;
    int          m_acc, m_rate, m_win, m_streak;
    bit          m_valid, m_ovr, m_high;

    always @(posedge fastclk) begin
        if (reset) begin
            m_init = 1'b1;
            sq_slow = '{1'b0, 1'b0, 1'b0};
            sq_step = '{1'b0, 1'b0, 1'b0};
            m_live = 0;
            m_acc = 0; m_rate = 0; m_win = 0; m_streak = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_high = 1'b0;
        end else if (m_init) begin
            bit b;
            bit sp;
            int nr;
            b  = (m_live >= 3) && (sq_slow[1] != sq_slow[2]);
            sp = (m_live >= 3) && sq_step[1] && !sq_step[2];
            m_high = (m_streak == HI_WINDOWS);
            if (b) begin
                nr = m_acc + int'(sp);
                if (nr > MAXV) nr = MAXV;
                m_rate = nr;
                m_acc = 0;
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_win = (m_win + 1) % (1 << WIN_W);
                if (nr >= HI_THRESH) m_streak = (m_streak < HI_WINDOWS) ? m_streak + 1 : HI_WINDOWS;
                else m_streak = 0;
            end else begin
                if (sp && m_acc < MAXV) m_acc = m_acc + 1;
                if (rd_ack) m_valid = 1'b0;
            end
            sq_slow.push_front(slowclk);
            void'(sq_slow.pop_back());
            sq_step.push_front(step);
            void'(sq_step.pop_back());
            if (m_live < 3) m_live = m_live + 1;
        end
    end

    always @(negedge fastclk) begin
        if (m_init) begin
            n_cmp++;
            if (rate !== CNT_W'(m_rate) || rate_valid !== m_valid || overrun !== m_ovr ||
                window_cnt !== WIN_W'(m_win) || high_activity !== m_high) begin
                n_err++;
                $display("FAIL model t=%0t rate=%0d/%0d valid=%b/%b ovr=%b/%b win=%0d/%0d high=%b/%b (dut/model)",
                         $time, rate, m_rate, rate_valid, m_valid, overrun, m_ovr,
                         window_cnt, m_win, high_activity, m_high);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge fastclk);
    endtask

    task automatic give_step();
        step = 1'b1; cyc(2);
        step = 1'b0; cyc(2);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) give_step();
    endtask

    task automatic ack();
        rd_ack = 1'b1; cyc(1);
        rd_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(2);
        reset = 1'b0; cyc(4);
    endtask

    task automatic close_window();
        slowclk = ~slowclk;
        cyc(4);
    endtask

    initial begin
        int len;
        // Reset-level suppression
        slowclk = 1'b1; step = 1'b1; reset = 1'b1;
        cyc(3);
        chk("reset_rate", int'(rate), 0);
        chk("reset_valid", int'(rate_valid), 0);
        reset = 1'b0;
        cyc(10);
        chk("supp_window", int'(window_cnt), 0);
        chk("supp_valid", int'(rate_valid), 0);
        step = 1'b0; cyc(4);

        // Basic count
        steps(5);
        close_window();
        chk("basic_rate", int'(rate), 5);
        chk("basic_valid", int'(rate_valid), 1);
        chk("basic_window", int'(window_cnt), 1);
        ack();
        chk("basic_ack", int'(rate_valid), 0);
        cyc(3);

        // Coincident step and boundary
        steps(3);
        slowclk = ~slowclk; step = 1'b1; cyc(2);
        step = 1'b0; cyc(2);
        chk("coinc_rate", int'(rate), 4);
        ack(); cyc(4);
        close_window();
        chk("coinc_next", int'(rate), 0);
        ack(); cyc(2);

        // Ack/boundary collision
        steps(2);
        slowclk = ~slowclk; cyc(2);
        rd_ack = 1'b1; cyc(1);
        rd_ack = 1'b0;
        chk("coll_valid", int'(rate_valid), 1);
        chk("coll_rate", int'(rate), 2);
        cyc(2);

        // High activity over 40,40,40,10
        steps(40); close_window(); cyc(1);
        chk("hi_w1", int'(high_activity), 0);
        steps(40); close_window(); cyc(1);
        steps(40); close_window(); cyc(1);
        chk("hi_w3", int'(high_activity), 1);
        steps(10); close_window(); cyc(1);
        chk("hi_w4", int'(high_activity), 0);

        // Saturation and overrun
        do_reset();
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_window", int'(window_cnt), 0);
        steps(300);
        close_window();
        chk("sat_rate", int'(rate), 255);
        chk("sat_ovr0", int'(overrun), 0);
        cyc(4);
        close_window();
        chk("ovr_set", int'(overrun), 1);
        ack(); cyc(2);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_ackd", int'(rate_valid), 0);

        // Random traffic with window_cnt wrap and occasional mid-window reset
        for (int w = 0; w < 40; w++) begin
            len = $urandom_range(8, 60);
            for (int c = 0; c < len; c++) begin
                @(negedge fastclk);
                if ($urandom_range(0, 2) == 0) step = ~step;
                rd_ack = ($urandom_range(0, 3) == 0);
                reset  = ($urandom_range(0, 299) == 0);
            end
            @(negedge fastclk);
            reset = 1'b0; rd_ack = 1'b0;
            slowclk = ~slowclk;
        end
        cyc(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
